// File: rtl/vga_capture_if.sv
// vga_capture_if: sampled VGA input stream and recovered pixel/status outputs
interface vga_capture_if;
    logic        pix_en;
    logic        hSync;
    logic        vSync;
    logic [11:0] rgb;
    logic        pix_valid;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [18:0] pix_addr;
    logic [11:0] pix_data;
    logic        frame_start;
    logic        locked;
    logic [7:0]  err_cnt;

    modport master (
        output pix_en, hSync, vSync, rgb,
        input  pix_valid, x, y, pix_addr, pix_data, frame_start, locked, err_cnt
    );

    modport slave (
        input  pix_en, hSync, vSync, rgb,
        output pix_valid, x, y, pix_addr, pix_data, frame_start, locked, err_cnt
    );
endinterface

// File: rtl/vga_capture.sv
// vga_capture: samples a VGA stream on pix_en, recovers pixel coordinates and tracks lock and length errors
module vga_capture #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int H_BACK   = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_BACK   = 33,
    parameter int V_TOTAL  = 525,
    parameter bit SYNC_POL = 1'b0
) (
    input logic clk,
    input logic reset,
    vga_capture_if.slave vid
);
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
    state_t state, state_nx;
    logic [1:0] rst_q;
    logic rst_s;
    logic hs_prev, vs_prev, vpend;
    logic [9:0] hcnt, vcnt, hc_cur, vc_cur, x_n;
    logic [8:0] y_n;
    logic h_edge, v_edge, fb, err, emit;

    assign rst_s = rst_q[1];
    assign vid.locked = state == LOCKED;

    // reset asserts immediately, releases two clk edges later
    always_ff @(posedge clk or negedge reset)
        if (!reset) rst_q <= '0;
        else rst_q <= {rst_q[0], 1'b1};

    // the sample carrying an hSync trailing edge is slot 0; counts describe the current sample
    always_comb begin
        h_edge = vid.pix_en && hs_prev && (vid.hSync != SYNC_POL);
        v_edge = vid.pix_en && vs_prev && (vid.vSync != SYNC_POL);
        fb = h_edge && (vpend || v_edge);
        hc_cur = h_edge ? 10'd0 : (&hcnt ? hcnt : hcnt + 10'd1);
        vc_cur = fb ? 10'd0 : h_edge ? (&vcnt ? vcnt : vcnt + 10'd1) : vcnt;
        err = (state != SEARCH) && ((h_edge && ({1'b0, hcnt} + 11'd1 != 11'(H_TOTAL))) ||
                                    (fb && ({1'b0, vcnt} + 11'd1 != 11'(V_TOTAL))));
        emit = vid.pix_en && (state == LOCKED) &&
               hc_cur >= 10'(H_BACK) && hc_cur < 10'(H_BACK + WIDTH) &&
               vc_cur >= 10'(V_BACK) && vc_cur < 10'(V_BACK + HEIGHT);
        x_n = hc_cur - 10'(H_BACK);
        y_n = 9'(vc_cur - 10'(V_BACK));
        state_nx = err ? SEARCH : !fb ? state : (state == SEARCH) ? MEASURE : LOCKED;
    end

    // sync history and position counters, advanced only on pix_en samples
    always_ff @(posedge clk or negedge rst_s)
        if (!rst_s) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            vpend <= 1'b0;
            hcnt <= '0;
            vcnt <= '0;
        end else if (vid.pix_en) begin
            hs_prev <= vid.hSync == SYNC_POL;
            vs_prev <= vid.vSync == SYNC_POL;
            vpend <= !h_edge && (vpend || v_edge);
            hcnt <= hc_cur;
            vcnt <= vc_cur;
        end

    // lock state and saturating length-error count
    always_ff @(posedge clk or negedge rst_s)
        if (!rst_s) begin
            state <= SEARCH;
            vid.err_cnt <= '0;
        end else begin
            state <= state_nx;
            if (err && !(&vid.err_cnt)) vid.err_cnt <= vid.err_cnt + 8'd1;
        end

    // registered pixel stream; coordinates and colour hold between pulses
    always_ff @(posedge clk or negedge rst_s)
        if (!rst_s) begin
            vid.pix_valid <= 1'b0;
            vid.frame_start <= 1'b0;
            vid.x <= '0;
            vid.y <= '0;
            vid.pix_addr <= '0;
            vid.pix_data <= '0;
        end else begin
            vid.pix_valid <= emit;
            vid.frame_start <= emit && x_n == 10'd0 && y_n == 9'd0;
            if (emit) begin
                vid.x <= x_n;
                vid.y <= y_n;
                vid.pix_addr <= 19'(x_n) + 19'(WIDTH) * 19'(y_n);
                vid.pix_data <= vid.rgb;
            end
        end
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: scoreboard bench on scaled-down timing, active-low and active-high sync instances in parallel
module tb_vga_capture;
    localparam int W = 8, H = 4, HB = 3, HT = 14, VB = 2, VT = 8;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int tot = 0, bad = 0, np0 = 0, np1 = 0, b0 = 0, b1 = 0;
    logic [50:0] q0[$], q1[$];
    logic [50:0] e0v, e1v;

    vga_capture_if vid0(), vid1();

    vga_capture #(.WIDTH(W), .HEIGHT(H), .H_BACK(HB), .H_TOTAL(HT), .V_BACK(VB), .V_TOTAL(VT), .SYNC_POL(1'b0))
        dut0 (.clk(clk), .reset(reset), .vid(vid0));
    vga_capture #(.WIDTH(W), .HEIGHT(H), .H_BACK(HB), .H_TOTAL(HT), .V_BACK(VB), .V_TOTAL(VT), .SYNC_POL(1'b1))
        dut1 (.clk(clk), .reset(reset), .vid(vid1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (vid0.pix_valid) begin
        e0v = '1;
        if (q0.size() > 0) e0v = q0.pop_front();
        chk("pix0", {vid0.frame_start, vid0.x, vid0.y, vid0.pix_addr, vid0.pix_data}, e0v);
        np0++;
    end

    always @(negedge clk) if (vid1.pix_valid) begin
        e1v = '1;
        if (q1.size() > 0) e1v = q1.pop_front();
        chk("pix1", {vid1.frame_start, vid1.x, vid1.y, vid1.pix_addr, vid1.pix_data}, e1v);
        np1++;
    end

    task automatic st(input string tag, input int lk, input int e);
        chk({tag, "_lk0"}, vid0.locked, lk);
        chk({tag, "_lk1"}, vid1.locked, lk);
        chk({tag, "_err0"}, vid0.err_cnt, e);
        chk({tag, "_err1"}, vid1.err_cnt, e);
    endtask

    task automatic z(input string tag);
        chk({tag, "0"}, {vid0.pix_valid, vid0.x, vid0.y, vid0.pix_addr, vid0.pix_data,
                         vid0.frame_start, vid0.locked, vid0.err_cnt}, 0);
        chk({tag, "1"}, {vid1.pix_valid, vid1.x, vid1.y, vid1.pix_addr, vid1.pix_data,
                         vid1.frame_start, vid1.locked, vid1.err_cnt}, 0);
    endtask

    // hs/vs are asserted flags; each instance gets them at its own polarity
    task automatic put(input logic hs, input logic vs, input logic [11:0] c, input int gap);
        int g;
        g = gap < 0 ? int'($urandom_range(0, 3)) : gap;
        vid0.pix_en = 1'b1; vid1.pix_en = 1'b1;
        vid0.hSync = ~hs; vid0.vSync = ~vs;
        vid1.hSync = hs; vid1.vSync = vs;
        vid0.rgb = c; vid1.rgb = c;
        @(posedge clk); #1;
        vid0.pix_en = 1'b0; vid1.pix_en = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
    endtask

    task automatic check_count(input string tag);
        chk({tag, "_n0"}, np0 - b0, W * H);
        chk({tag, "_n1"}, np1 - b1, W * H);
        chk({tag, "_last0"}, {vid0.x, vid0.y, vid0.pix_addr}, {10'(W - 1), 9'(H - 1), 19'(W * H - 1)});
        chk({tag, "_last1"}, {vid1.x, vid1.y, vid1.pix_addr}, {10'(W - 1), 9'(H - 1), 19'(W * H - 1)});
    endtask

    // nl lines; line sl is slen slots; vSync trails at slot vend of the last line;
    // pixels expected on lines < plim; lk/e0 checked after first sample, e1 after the short-line edge
    task automatic frame(input int nl, input int sl, input int slen, input int vend, input int plim,
                         input int lk, input int e0, input int e1, input int gap, input int ns);
        int n, len, px, py;
        logic [11:0] c;
        n = 0;
        b0 = np0; b1 = np1;
        for (int l = 0; l < nl; l++) begin
            len = (l == sl) ? slen : HT;
            for (int s = 0; s < len; s++) begin
                if (ns >= 0 && n == ns) return;
                px = s - HB;
                py = l - VB;
                c = {px[3:0], py[3:0], 4'h5};
                if (sl >= 0 && l == sl + 1 && s == 0) st("pre_err", 1, e0);
                if (l < plim && px >= 0 && px < W && py >= 0 && py < H) begin
                    q0.push_back({px == 0 && py == 0, 10'(px), 9'(py), 19'(px + W * py), c});
                    q1.push_back({px == 0 && py == 0, 10'(px), 9'(py), 19'(px + W * py), c});
                end
                put(s >= len - 2, l == nl - 2 || (l == nl - 1 && s < vend), c, gap);
                n++;
                if (n == 1) st("first", lk, e0);
                if (sl >= 0 && l == sl + 1 && s == 0) st("line_err", 0, e1);
            end
        end
    endtask

    task automatic pulse_reset(input string tag);
        #2 reset = 1'b0;
        #1 z(tag);
        repeat (3) @(posedge clk);
        #1 z({tag, "_hold"});
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // short lines with a vSync trailing edge in every line: alternating boundary / error
    task automatic errlines(input int n);
        for (int l = 0; l < n; l++)
            for (int s = 0; s < 5; s++)
                put(s >= 3, s < 2, 12'($urandom), 0);
    endtask

    initial begin
        vid0.pix_en = 1'b0; vid1.pix_en = 1'b0;
        vid0.hSync = 1'b1; vid0.vSync = 1'b1;
        vid1.hSync = 1'b0; vid1.vSync = 1'b0;
        vid0.rgb = '0; vid1.rgb = '0;
        #21 z("rst");
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        // clean stream: partial frame, measure frame, then locked frame
        frame(VT, -1, 0, HT, 0, 0, 0, 0, 3, -1);
        frame(VT, -1, 0, HT, 0, 0, 0, 0, 3, -1);
        st("pre_lock", 0, 0);
        frame(VT, -1, 0, 6, VT, 1, 0, 0, 3, -1);
        check_count("f3");
        // one line of HT-1 slots while locked
        frame(VT, 4, HT - 1, HT, 5, 1, 0, 1, 3, -1);
        frame(VT, -1, 0, HT, 0, 0, 1, 0, 3, -1);
        frame(VT, -1, 0, HT, VT, 1, 1, 0, 3, -1);
        check_count("relock1");
        // frame of VT-1 lines
        frame(VT - 1, -1, 0, HT, VT, 1, 1, 0, 3, -1);
        frame(VT, -1, 0, HT, 0, 0, 2, 0, 3, -1);
        frame(VT, -1, 0, HT, 0, 0, 2, 0, 3, -1);
        frame(VT, -1, 0, HT, VT, 1, 2, 0, 3, -1);
        check_count("relock2");
        // reset mid-line while locked, then random pix_en gaps
        frame(VT, -1, 0, HT, VT, 1, 2, 0, 3, 3 * HT + 6 + 1);
        st("pre_rst", 1, 2);
        pulse_reset("mid_rst");
        frame(VT, -1, 0, HT, 0, 0, 0, 0, -1, -1);
        frame(VT, -1, 0, 6, 0, 0, 0, 0, -1, -1);
        frame(VT, -1, 0, HT, VT, 1, 0, 0, -1, -1);
        check_count("post_rst");
        // error counter: exact count then saturation
        pulse_reset("err_rst");
        errlines(201);
        st("err100", 0, 100);
        errlines(400);
        st("err_sat", 0, 255);
        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule

// File: doc/vga_capture.md
# vga_capture

Receive-side counterpart of the VGA timing generator: samples an incoming 640x480 VGA stream (hSync, vSync, 12-bit RGB) on a pixel-rate strobe and recovers pixel coordinates from the sync edges. Emits a write-ready pixel stream (coordinates, linear address, colour) suitable for a frame-buffer RAM write port. Checks line and frame lengths, and tracks lock and timing-error status. Used as a loopback checker for the display path and as the front end of a frame grabber.

## Interface

- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- H_BACK, 48, pixel slots from the hSync trailing edge to x=0
- H_TOTAL, 800, pixel slots per line
- V_BACK, 33, lines from the vSync trailing edge to y=0
- V_TOTAL, 525, lines per frame
- SYNC_POL, 0, asserted level of hSync/vSync (0 = active-low)

Ports:

- clk  in  1  100 MHz system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low reset; deassertion is synchronised to clk internally
- pix_en  in  1  one-clk strobe at pixel rate (25 MHz); all inputs below are sampled only when pix_en=1
- hSync  in  1  horizontal sync
- vSync  in  1  vertical sync
- rgb  in  12  {R,G,B} colour, 4 bits per channel
- pix_valid  out  1  one-clk pulse: x/y/pix_addr/pix_data hold an active pixel
- x  out  10  recovered column, 0..WIDTH-1
- y  out  9  recovered row, 0..HEIGHT-1
- pix_addr  out  19  x + WIDTH*y
- pix_data  out  12  sampled rgb
- frame_start  out  1  one-clk pulse together with pix_valid for pixel (0,0)
- locked  out  1  timing lock status
- err_cnt  out  8  saturating count of line/frame length errors

## Operation

- Pixel counter hcnt (10 b) increments on every pix_en.
- Trailing-edge detect on hSync, on a pix_en sample: the previous sample is asserted and the current sample is deasserted. On that sample:
  - hcnt is cleared to 0.
  - The line-length check runs: the old hcnt+1 must equal H_TOTAL.
- Line counter vcnt (10 b) increments on each hSync trailing edge.
- A vSync trailing edge sets vpend. The next hSync trailing edge clears vcnt to 0 and clears vpend. At that point the frame-length check runs: the old vcnt+1 must equal V_TOTAL.
- A pixel is active when H_BACK ≤ hcnt < H_BACK+WIDTH and V_BACK ≤ vcnt < V_BACK+HEIGHT. For an active pixel:
  - x = hcnt−H_BACK
  - y = vcnt−V_BACK
  - pix_addr = x + WIDTH*y, computed as a 19-bit unsigned multiply-add
- Lock FSM states:
  - SEARCH: the first frame boundary (vcnt clear) goes to MEASURE.
  - MEASURE: a frame boundary is reached with every line length and the frame length correct goes to LOCKED. Any error returns to SEARCH.
  - LOCKED: any line or frame length error goes to SEARCH.
- locked = (state == LOCKED).
- Every length error increments err_cnt, saturating at 255. Errors are counted in every state except the first (partial) frame in SEARCH.
- pix_valid is asserted only in LOCKED. No pixels are emitted while searching.
- Boundary rules:
  - hcnt saturates at 1023 and vcnt saturates at 1023 when sync is missing. A missing sync therefore yields a length error at the next edge; with no edge at all, lock holds until an edge arrives.
  - When vSync and hSync trailing edges land on the same sample, the hSync edge does both the vcnt clear and the length check.
- Reset assertion, including mid-frame, forces:
  - SEARCH state
  - hcnt=0, vcnt=0, vpend=0, err_cnt=0
  - all outputs 0

## Timing

- Outputs are registered. pix_valid, x, y, pix_addr, pix_data and frame_start update on the clk edge after the edge that sampled pix_en=1, a latency of 1 clk.
- pix_valid is high for exactly 1 clk per active pixel and is 0 on clks with pix_en=0.
- Between pulses, x, y, pix_addr and pix_data hold their last values.
- The locked transition to 1 occurs 1 clk after the sample carrying the qualifying hSync edge. The transition to 0 occurs 1 clk after the error sample, in the same cycle err_cnt increments.
- Throughput: one pixel per pix_en, with no backpressure. pix_en may have arbitrary gaps; counting depends only on pix_en samples.
- Reset values: pix_valid=0, x=0, y=0, pix_addr=0, pix_data=0, frame_start=0, locked=0, err_cnt=0.

## Test plan

- Ideal 640x480@60 stream, pix_en every 4th clk, rgb = x[3:0],y[3:0],4'h5 -> locked=1 after the second vSync boundary. The third frame gives pix_valid on (0,0) with frame_start=1 and pix_data=12'h005, and the last pixel gives x=639, y=479, pix_addr=307199. There are exactly 307200 pix_valid pulses per frame.
- Locked stream with one line shortened to 799 slots -> locked falls 1 clk after that hSync edge, err_cnt=1, no pix_valid for the rest of the frame, and lock returns after one further clean frame.
- Frame with 524 lines -> err_cnt increments by 1, locked=0, and relock follows.
- Reset pulsed low mid-line while locked -> all outputs 0 asynchronously. After release: SEARCH state, first pix_valid only after two complete frames.
- SYNC_POL=1 instance fed inverted syncs -> identical x/y/pix_addr sequence to the first scenario.
- 300 forced length errors -> err_cnt holds at 255.
